// File: rtl/rec2pol_sched_pkg.sv
// +----------------------------------------------------------------------+
// | rec2pol_sched_pkg : shared types and constants for the rec2pol_sched |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package rec2pol_sched_pkg;

  localparam int LATENCY_DEFAULT = 32;
  localparam int FRAC_MOD        = 16;
  localparam int FRAC_ANG        = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Id width, never narrower than one bit.
  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rec2pol_sched_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin picker, search starts at last+1  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  // Walk from farthest to nearest so the requester closest to last+1 wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        any    = 1'b1;
        winner = IDW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rec2pol_sched.sv
// +----------------------------------------------------------------------+
// | rec2pol_sched : round-robin sharing of one rec2pol CORDIC unit       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rec2pol_sched
  import rec2pol_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int LATENCY = LATENCY_DEFAULT,
  localparam int IDW     = idw_of(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   x_in,
  input  logic [NREQ*32-1:0]   y_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [IDW-1:0]       done_id,
  output logic [31:0]          mod_out,
  output logic [31:0]          angle_out,
  output logic                 busy,
  output logic                 cordic_start,
  output logic                 cordic_enable,
  output logic [31:0]          cordic_x,
  output logic [31:0]          cordic_y,
  input  logic [31:0]          cordic_mod,
  input  logic [31:0]          cordic_angle
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [31:0]       mod_q, mod_d;
  logic [31:0]       ang_q, ang_d;
  logic [31:0]       x_q, x_d;
  logic [31:0]       y_q, y_d;

  logic              pick_any;
  logic [IDW-1:0]    pick_win;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= IDW'(NREQ - 1);
      id_q      <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      done_id_q <= '0;
      mod_q     <= '0;
      ang_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      mod_q     <= mod_d;
      ang_q     <= ang_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    id_d      = id_q;
    gnt_d     = '0;
    done_d    = '0;
    done_id_d = done_id_q;
    mod_d     = mod_q;
    ang_d     = ang_q;
    x_d       = x_q;
    y_d       = y_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d         = ST_LOAD;
          last_d          = pick_win;
          id_d            = pick_win;
          gnt_d[pick_win] = 1'b1;
          x_d             = x_in[32*pick_win +: 32];
          y_d             = y_in[32*pick_win +: 32];
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = CW'(LATENCY - 1);
      end
      ST_RUN: begin
        // CORDIC result is sampled on the same edge that leaves RUN.
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          mod_d        = cordic_mod;
          ang_d        = cordic_angle;
          done_id_d    = id_q;
          done_d[id_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign done_id       = done_id_q;
  assign mod_out       = mod_q;
  assign angle_out     = ang_q;
  assign busy          = (state_q != ST_IDLE);
  assign cordic_start  = (state_q == ST_LOAD);
  assign cordic_enable = busy;
  assign cordic_x      = x_q;
  assign cordic_y      = y_q;

endmodule

`default_nettype wire

// File: tb/tb_rec2pol_sched.sv
// +----------------------------------------------------------------------+
// | tb_rec2pol_sched : scoreboard bench with a behavioural rec2pol model |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rec2pol_sched;
  import rec2pol_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 32;
  localparam int IDW  = idw_of(NREQ);

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*32-1:0]  x_in, y_in;
  logic [NREQ-1:0]     gnt, done;
  logic [IDW-1:0]      done_id;
  logic [31:0]         mod_out, angle_out;
  logic                busy, cordic_start, cordic_enable;
  logic [31:0]         cordic_x, cordic_y, cordic_mod, cordic_angle;

  always #5 clock = ~clock;

  rec2pol_sched #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(gnt), .done(done), .done_id(done_id), .mod_out(mod_out),
    .angle_out(angle_out), .busy(busy), .cordic_start(cordic_start),
    .cordic_enable(cordic_enable), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_mod(cordic_mod), .cordic_angle(cordic_angle)
  );

  // Behavioural rec2pol: result is only presented once enable has been held
  // for exactly the iteration latency after start; otherwise it is poison.
  function automatic logic [31:0] conv_mod(input logic [31:0] x, input logic [31:0] y);
    real    sm = real'(longint'(1) << FRAC_MOD);
    real    xr = $itor($signed(x)) / sm;
    real    yr = $itor($signed(y)) / sm;
    longint v  = longint'($sqrt(xr*xr + yr*yr) * sm);
    return v[31:0];
  endfunction

  function automatic logic [31:0] conv_ang(input logic [31:0] x, input logic [31:0] y);
    real    sa  = real'(longint'(1) << FRAC_ANG);
    real    deg = $atan2($itor($signed(y)), $itor($signed(x))) * 180.0 / 3.14159265358979;
    longint v   = longint'(deg * sa);
    return v[31:0];
  endfunction

  logic [31:0] m_res = '0, a_res = '0;
  int          c_cnt = 0;
  always @(posedge clock) begin
    if (cordic_start && cordic_enable) begin
      m_res <= conv_mod(cordic_x, cordic_y);
      a_res <= conv_ang(cordic_x, cordic_y);
      c_cnt <= 0;
    end else if (cordic_enable) begin
      c_cnt <= c_cnt + 1;
    end
  end
  assign cordic_mod   = (cordic_enable && c_cnt == LAT-1) ? m_res : 32'hDEAD_BEEF;
  assign cordic_angle = (cordic_enable && c_cnt == LAT-1) ? a_res : 32'hDEAD_BEEF;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
    int diff;
    n_cmp++;
    diff = int'(obs - exp);
    if (diff < 0) diff = -diff;
    if ($isunknown(obs) || diff > tol) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h) tol %0d",
               tag, obs, obs, exp, exp, tol);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] m;
    logic [31:0] a;
    int          tm;
    int          ta;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   done_cyc[$];
  int   cyc = 0, last_gnt_cyc = 0;
  logic prev_gnt = 1'b0;
  exp_t e;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (prev_gnt) begin
      chk("start_one_cycle", {31'd0, cordic_start}, 32'd0, 0);
      chk("enable_in_run",   {31'd0, cordic_enable}, 32'd1, 0);
    end
    prev_gnt = (gnt != '0);
    if (gnt != '0) begin
      chk("gnt_onehot", $countones(gnt), 32'd1, 0);
      chk("start_in_load", {31'd0, cordic_start}, 32'd1, 0);
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
      last_gnt_cyc = cyc;
    end
    if (done != '0) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0, 0);
      end else begin
        e = sb.pop_front();
        chk("done_onehot", 32'(done), 32'(1 << e.id), 0);
        chk("done_id", 32'(done_id), 32'(e.id), 0);
        chk("mod_out", mod_out, e.m, e.tm);
        chk("angle_out", angle_out, e.a, e.ta);
        chk("gnt_to_done", cyc - last_gnt_cyc, LAT + 1, 0);
      end
      done_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    x_in[32*i +: 32] = x;
    y_in[32*i +: 32] = y;
  endtask

  task automatic expect_res(input int id, input logic [31:0] m, input logic [31:0] a,
                            input int tm, input int ta);
    exp_t t;
    t.id = id; t.m = m; t.a = a; t.tm = tm; t.ta = ta;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // hold_n == 0: drop each requester as soon as it is granted;
  // hold_n  > 0: hold all requests until hold_n grants have been seen.
  task automatic run(input int budget, input int hold_n);
    int ng = 0;
    int n  = 0;
    while (n < budget && !(sb.size() == 0 && !busy && req == '0 && gnt == '0)) begin
      tick();
      n++;
      if (gnt != '0) begin
        ng++;
        if (hold_n == 0) req = req & ~gnt;
        else if (ng >= hold_n) req = '0;
      end
    end
    chk("drain", sb.size(), 32'd0, 0);
  endtask

  task automatic chk_order(input string tag, input int base, input int exp_ids[4], input int cnt);
    chk({tag, "_count"}, gnt_log.size() - base, cnt, 0);
    for (int i = 0; i < cnt; i++)
      if (base + i < gnt_log.size()) chk(tag, gnt_log[base+i], exp_ids[i], 0);
  endtask

  task automatic chk_period(input int base);
    for (int i = base + 1; i < done_cyc.size(); i++)
      chk("done_period", done_cyc[i] - done_cyc[i-1], LAT + 2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d;
    reset = 1'b1;
    req   = '1;
    x_in  = '0;
    y_in  = '0;

    // Reset holds everything at zero even with all requests pending.
    tick();
    tick();
    chk("rst_gnt",     32'(gnt), 0, 0);
    chk("rst_done",    32'(done), 0, 0);
    chk("rst_done_id", 32'(done_id), 0, 0);
    chk("rst_mod",     mod_out, 0, 0);
    chk("rst_angle",   angle_out, 0, 0);
    chk("rst_busy",    {31'd0, busy}, 0, 0);
    chk("rst_start",   {31'd0, cordic_start}, 0, 0);
    chk("rst_enable",  {31'd0, cordic_enable}, 0, 0);
    chk("rst_cx",      cordic_x, 0, 0);
    chk("rst_cy",      cordic_y, 0, 0);
    expect_res(0, 32'd0, 32'd0, 16, 16);
    reset = 1'b0;
    tick();
    chk("first_gnt", 32'(gnt), 32'd1, 0);
    req = '0;
    run(2000, 0);

    // Single request; operand change after grant must not matter.
    set_op(0, 32'h003C_0000, 32'hFFC4_0000);
    expect_res(0, 32'd5560914, -32'sd754974720, 5561, 754975);
    b   = gnt_log.size();
    req = 4'b0001;
    tick();
    chk("single_gnt", 32'(gnt), 32'd1, 0);
    req = '0;
    x_in[31:0] = 32'h0;
    run(2000, 0);
    chk_order("single_order", b, '{0, 0, 0, 0}, 1);

    // All four at once from a fresh last pointer.
    do_reset();
    set_op(0, 32'h000A_0000, 32'h0);
    set_op(1, 32'h0,         32'h000A_0000);
    set_op(2, 32'hFFF6_0000, 32'h0);
    set_op(3, 32'h0003_0000, 32'h0004_0000);
    expect_res(0, 32'd655360, 32'd0,          656, 16384);
    expect_res(1, 32'd655360, 32'd1509949440, 656, 1509950);
    expect_res(2, 32'd655360, 32'hB400_0000,  656, 3019899);
    expect_res(3, 32'd327680, 32'd891375204,  328, 891376);
    b   = gnt_log.size();
    d   = done_cyc.size();
    req = 4'b1111;
    run(3000, 0);
    chk_order("all4_order", b, '{0, 1, 2, 3}, 4);
    chk_period(d);

    // Fairness between two continuously held requesters.
    expect_res(0, 32'd655360, 32'd0,         656, 16384);
    expect_res(2, 32'd655360, 32'hB400_0000, 656, 3019899);
    expect_res(0, 32'd655360, 32'd0,         656, 16384);
    expect_res(2, 32'd655360, 32'hB400_0000, 656, 3019899);
    b   = gnt_log.size();
    d   = done_cyc.size();
    req = 4'b0101;
    run(3000, 4);
    chk_order("fair_order", b, '{0, 2, 0, 2}, 4);
    chk_period(d);

    // Reset in the middle of RUN aborts without a done pulse.
    set_op(1, 32'h0003_0000, 32'h0004_0000);
    req = 4'b0010;
    tick();
    chk("abort_gnt", 32'(gnt), 32'b0010, 0);
    req = '0;
    repeat (10) tick();
    chk("abort_busy_before", {31'd0, busy}, 1, 0);
    d     = done_cyc.size();
    reset = 1'b1;
    tick();
    chk("abort_busy",   {31'd0, busy}, 0, 0);
    chk("abort_done",   32'(done), 0, 0);
    chk("abort_enable", {31'd0, cordic_enable}, 0, 0);
    chk("abort_mod",    mod_out, 0, 0);
    reset = 1'b0;
    repeat (40) tick();
    chk("abort_no_done", done_cyc.size() - d, 0, 0);

    expect_res(1, 32'd327680, 32'd891375204, 328, 891376);
    req = 4'b0010;
    run(2000, 0);

    // A request withdrawn before any edge samples it is never granted.
    b = gnt_log.size();
    tick();
    req = 4'b1000;
    #2;
    req = '0;
    repeat (5) tick();
    chk("req3_withdrawn", gnt_log.size() - b, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
